ultrasound_scan_sched: RTL and testbench
========================================

ULTRASOUND_SCAN_SCHED -- requirements
Module: ultrasound_scan_sched

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 277, giving the half-period of the drive square wave as HALF_PERIOD+1 clocks (≈90 kHz at 50 MHz).
REQ-002 SHALL have parameter PULSES, default 8, giving the number of drive periods per burst (1..255).
REQ-003 SHALL have parameter BLANK_CYC, default 5_000, giving the ringdown blanking length in clocks after the burst.
REQ-004 SHALL have parameter WINDOW, default 499_999, giving the last counter value of a channel slot (10 ms at 50 MHz); it SHALL exceed the burst length plus BLANK_CYC.
REQ-005 SHALL have parameter TOF_W, default 19, giving the counter and tof width; it SHALL be able to hold WINDOW.
REQ-006 Port clk_50M, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 Port enable, input, 1 bit: while high, the block scans the enabled channels continuously.
REQ-009 Port chan_mask, input, 4 bits: bit i enables channel i.
REQ-010 Port echo, input, 4 bits: asynchronous echo comparator outputs, one per channel.
REQ-011 Port vin, output, 4 bits: transducer drive, bit i drives channel i.
REQ-012 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 Port tof_valid, output, 1 bit: one-cycle result strobe.
REQ-014 Port tof, output, TOF_W bits: time of flight in clocks, counted from burst start.
REQ-015 Port tof_chan, output, 2 bits: the channel that the result belongs to.
REQ-016 Port timeout, output, 1 bit: qualifies tof_valid; high means no echo was detected in the window.

Function
REQ-017 The FSM SHALL have the states IDLE, SELECT, BURST, BLANK, LISTEN and REPORT.
REQ-018 IDLE SHALL go to SELECT when enable=1 and chan_mask≠0; otherwise it SHALL stay in IDLE.
REQ-019 SELECT (1 cycle) SHALL sample chan_mask and pick the next enabled channel round-robin, starting from last_chan+1 mod 4; it SHALL go to IDLE if the mask is 0, else to BURST.
REQ-020 On entry to BURST the slot counter SHALL be 0; it SHALL increment every cycle through BURST, BLANK and LISTEN.
REQ-021 In BURST, vin[ch] SHALL be high for HALF_PERIOD+1 clocks, then low for HALF_PERIOD+1 clocks, repeated PULSES times, starting high at counter 0.
REQ-022 In every cycle outside BURST, all vin bits SHALL be 0, and vin bits of non-selected channels SHALL always be 0.
REQ-023 BLANK SHALL last exactly BLANK_CYC cycles, and echo SHALL be ignored during it.
REQ-024 Each echo bit SHALL pass through a 2-flop synchronizer; a detection is a 0→1 transition of the synchronized echo[ch], seen in LISTEN only.
REQ-025 On the first detection in a slot, tof SHALL be captured as the counter value in that cycle (synchronizer delay is not compensated); later edges in the same slot SHALL be ignored.
REQ-026 LISTEN SHALL persist until counter==WINDOW regardless of echo, so slot length is fixed.
REQ-027 REPORT (1 cycle) SHALL assert tof_valid=1 with tof_chan=ch; with a detection, timeout=0 and tof=captured value; with none, timeout=1 and tof=WINDOW.
REQ-028 tof, tof_chan and timeout SHALL hold their values until the next REPORT.
REQ-029 After REPORT, last_chan SHALL become ch; the FSM SHALL go to SELECT if enable=1, else to IDLE.
REQ-030 Deasserting enable mid-slot SHALL not abort the slot: the burst, window and report complete first.
REQ-031 A chan_mask change SHALL take effect only at the next SELECT.
REQ-032 Slot period SHALL be WINDOW+3 clocks (SELECT + WINDOW+1 counted cycles + REPORT).

Reset
REQ-033 When rst=1 at a clock edge, the block SHALL go to IDLE, with vin=0, busy=0, tof_valid=0, tof=0, tof_chan=0, timeout=0, counter=0, synchronizers cleared, and last_chan=3, so that channel 0 is first.
REQ-034 Reset SHALL take priority over all other inputs, including mid-burst, where vin SHALL be 0 in the cycle after rst is sampled.

Verification (HALF_PERIOD=2, PULSES=2, BLANK_CYC=4, WINDOW=40)
REQ-035 Burst shape: enable=1, chan_mask=0001 -> vin[0] reads 1,1,1,0,0,0,1,1,1,0,0,0 at counter 0..11, then 0; vin[3:1] are 0 throughout.
REQ-036 Echo capture: echo[0] rises so that the synchronized edge occurs at counter 25 -> one tof_valid cycle after counter 40 with tof=25, tof_chan=0, timeout=0.
REQ-037 Blanking/timeout: echo[0] pulses only at counter 12..14 -> tof=40, timeout=1.
REQ-038 Round-robin: chan_mask=0101, continuous enable -> reports for chan 0, 2, 0, 2, with tof_valid strobes 43 clocks apart.
REQ-039 Enable drop: enable goes to 0 at counter 5 -> the slot still reports; busy falls the cycle after REPORT and no further vin activity follows.
REQ-040 Reset mid-burst: rst=1 at counter 3 -> the next cycle shows IDLE, vin=0, busy=0, and the next scan starts at channel 0.

Source files
------------

// File: rtl/ultrasound_scan_sched.sv
// Ultrasound time-of-flight scheduler: round-robin burst, ringdown blanking and echo listening
// over four transducer channels, one fixed-length slot per channel.
module ultrasound_scan_sched #(
    parameter int HALF_PERIOD = 277,
    parameter int PULSES      = 8,
    parameter int BLANK_CYC   = 5_000,
    parameter int WINDOW      = 499_999,
    parameter int TOF_W       = 19
) (
    input  logic             clk_50M,
    input  logic             rst,
    input  logic             enable,
    input  logic [3:0]       chan_mask,
    input  logic [3:0]       echo,
    output logic [3:0]       vin,
    output logic             busy,
    output logic             tof_valid,
    output logic [TOF_W-1:0] tof,
    output logic [1:0]       tof_chan,
    output logic             timeout
);
    localparam int HP_W      = $clog2(HALF_PERIOD + 2);
    localparam int BURST_LEN = 2 * (HALF_PERIOD + 1) * PULSES;
    localparam logic [HP_W-1:0]  HP_LAST    = HP_W'(HALF_PERIOD);
    localparam logic [HP_W-1:0]  HP_ONE     = HP_W'(1);
    localparam logic [TOF_W-1:0] CNT_ONE    = TOF_W'(1);
    localparam logic [TOF_W-1:0] BURST_LAST = TOF_W'(BURST_LEN - 1);
    localparam logic [TOF_W-1:0] BLANK_LAST = TOF_W'(BURST_LEN + BLANK_CYC - 1);
    localparam logic [TOF_W-1:0] WIN_LAST   = TOF_W'(WINDOW);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_BURST  = 3'd2,
        S_BLANK  = 3'd3,
        S_LISTEN = 3'd4,
        S_REPORT = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [TOF_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ch_q, ch_d;
    logic [1:0]       last_q, last_d;
    logic [HP_W-1:0]  hp_q, hp_d;
    logic             level_q, level_d;
    logic             found_q, found_d;
    logic [TOF_W-1:0] cap_q, cap_d;
    logic [3:0]       sync1_q, sync2_q, sync3_q;
    logic [3:0]       vin_q, vin_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [TOF_W-1:0] tof_q, tof_d;
    logic [1:0]       chan_q, chan_d;
    logic             timeout_q, timeout_d;
    logic             hit_s;

    // First enabled channel after 'last', wrapping; the smallest step wins.
    function automatic logic [1:0] pick_chan(input logic [1:0] last, input logic [3:0] mask);
        logic [1:0] c;
        logic [1:0] r;
        r = last;
        for (int i = 4; i >= 1; i--) begin
            c = last + 2'(i);
            r = mask[c] ? c : r;
        end
        return r;
    endfunction

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ch_q      <= 2'd0;
            last_q    <= 2'd3;
            hp_q      <= '0;
            level_q   <= 1'b0;
            found_q   <= 1'b0;
            cap_q     <= '0;
            sync1_q   <= 4'd0;
            sync2_q   <= 4'd0;
            sync3_q   <= 4'd0;
            vin_q     <= 4'd0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            tof_q     <= '0;
            chan_q    <= 2'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            last_q    <= last_d;
            hp_q      <= hp_d;
            level_q   <= level_d;
            found_q   <= found_d;
            cap_q     <= cap_d;
            sync1_q   <= echo;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            vin_q     <= vin_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            tof_q     <= tof_d;
            chan_q    <= chan_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic; the slot length is fixed by the counter alone.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = (enable && (chan_mask != 4'd0)) ? S_SELECT : S_IDLE;
            S_SELECT: state_d = (chan_mask != 4'd0) ? S_BURST : S_IDLE;
            S_BURST:  state_d = (cnt_q == BURST_LAST) ? S_BLANK : S_BURST;
            S_BLANK:  state_d = (cnt_q == BLANK_LAST) ? S_LISTEN : S_BLANK;
            S_LISTEN: state_d = (cnt_q == WIN_LAST) ? S_REPORT : S_LISTEN;
            S_REPORT: state_d = enable ? S_SELECT : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and next output values; outputs are taken straight from registers.
    always_comb begin
        hit_s     = (state_q == S_LISTEN) && sync2_q[ch_q] && !sync3_q[ch_q] && !found_q;
        ch_d      = ch_q;
        last_d    = last_q;
        hp_d      = hp_q;
        level_d   = level_q;
        found_d   = found_q;
        cap_d     = cap_q;
        tof_d     = tof_q;
        chan_d    = chan_q;
        timeout_d = timeout_q;
        valid_d   = 1'b0;
        busy_d    = (state_d != S_IDLE);
        if (((state_q == S_BURST) || (state_q == S_BLANK) || (state_q == S_LISTEN))
            && (state_d != S_REPORT)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = '0;
        end
        if (state_q == S_SELECT) begin
            ch_d    = pick_chan(last_q, chan_mask);
            found_d = 1'b0;
            hp_d    = '0;
            level_d = 1'b1;
        end else if (state_q == S_BURST) begin
            hp_d    = (hp_q == HP_LAST) ? '0 : (hp_q + HP_ONE);
            level_d = (hp_q == HP_LAST) ? !level_q : level_q;
        end else if (state_q == S_REPORT) begin
            last_d = ch_q;
        end else begin
            hp_d = hp_q;
        end
        if (hit_s) begin
            found_d = 1'b1;
            cap_d   = cnt_q;
        end else begin
            cap_d = cap_q;
        end
        // A hit in the final listen cycle must still reach this report.
        if (state_d == S_REPORT) begin
            valid_d   = 1'b1;
            chan_d    = ch_q;
            timeout_d = !(found_q || hit_s);
            tof_d     = hit_s ? cnt_q : (found_q ? cap_q : WIN_LAST);
        end else begin
            valid_d = 1'b0;
        end
        if ((state_d == S_BURST) && level_d) begin
            vin_d = 4'b0001 << ch_d;
        end else begin
            vin_d = 4'd0;
        end
    end

    assign vin       = vin_q;
    assign busy      = busy_q;
    assign tof_valid = valid_q;
    assign tof       = tof_q;
    assign tof_chan  = chan_q;
    assign timeout   = timeout_q;
endmodule

// File: tb/tb_ultrasound_scan_sched.sv
// Self-checking bench: slot-offset reference model compared every cycle, plus directed scenarios.
module tb_ultrasound_scan_sched;
    localparam int H  = 2;
    localparam int P  = 2;
    localparam int BC = 4;
    localparam int W  = 40;
    localparam int TW = 19;
    localparam int BL = 2 * (H + 1) * P;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [3:0]    chan_mask = 4'd0;
    logic [3:0]    echo = 4'd0;
    logic [3:0]    vin;
    logic          busy;
    logic          tof_valid;
    logic [TW-1:0] tof;
    logic [1:0]    tof_chan;
    logic          timeout;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: position in the slot counted from SELECT (k=0), REPORT is k=W+2.
    bit       m_on = 1'b0;
    bit       m_idle = 1'b1;
    int       m_k = 0;
    int       m_ch = 0;
    int       m_last = 3;
    bit       m_found = 1'b0;
    int       m_cap = 0;
    logic [3:0] h0 = 4'd0, h1 = 4'd0, h2 = 4'd0;
    logic [3:0] exp_vin = 4'd0;
    bit       exp_busy = 1'b0;
    bit       exp_valid = 1'b0;
    int       exp_tof = 0;
    int       exp_chan = 0;
    bit       exp_to = 1'b0;

    ultrasound_scan_sched #(
        .HALF_PERIOD(H), .PULSES(P), .BLANK_CYC(BC), .WINDOW(W), .TOF_W(TW)
    ) dut (
        .clk_50M(clk), .rst(rst), .enable(enable), .chan_mask(chan_mask), .echo(echo),
        .vin(vin), .busy(busy), .tof_valid(tof_valid), .tof(tof), .tof_chan(tof_chan),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, req);
        end
    endtask

    function automatic int pick(input int last, input logic [3:0] m);
        for (int i = 1; i <= 4; i++) begin
            if (m[(last + i) % 4]) return (last + i) % 4;
        end
        return last;
    endfunction

    // Reference model, advanced at each rising edge from the inputs sampled there.
    initial begin
        int c;
        forever begin
            @(posedge clk);
            h2 = h1; h1 = h0; h0 = echo;
            if (rst) begin
                m_on = 1'b1; m_idle = 1'b1; m_k = 0; m_last = 3; m_found = 1'b0;
                h0 = 4'd0; h1 = 4'd0; h2 = 4'd0;
                exp_vin = 4'd0; exp_busy = 1'b0; exp_valid = 1'b0;
                exp_tof = 0; exp_chan = 0; exp_to = 1'b0;
            end else begin
                if (m_idle) begin
                    if (enable && chan_mask != 4'd0) begin m_idle = 1'b0; m_k = 0; end
                end else if (m_k == 0) begin
                    if (chan_mask == 4'd0) m_idle = 1'b1;
                    else begin m_ch = pick(m_last, chan_mask); m_k = 1; m_found = 1'b0; end
                end else if (m_k == W + 2) begin
                    m_last = m_ch;
                    if (enable) m_k = 0; else m_idle = 1'b1;
                end else begin
                    m_k++;
                end
                c = m_k - 1;
                if (!m_idle && m_k >= 1 && m_k <= W + 1 && c >= BL + BC && !m_found
                    && h1[m_ch] && !h2[m_ch]) begin
                    m_found = 1'b1; m_cap = c;
                end
                exp_busy  = !m_idle;
                exp_vin   = (!m_idle && m_k >= 1 && c < BL && ((c / (H + 1)) % 2 == 0))
                            ? (4'b0001 << m_ch) : 4'd0;
                exp_valid = !m_idle && m_k == W + 2;
                if (exp_valid) begin
                    exp_tof = m_found ? m_cap : W; exp_to = !m_found; exp_chan = m_ch;
                end
            end
        end
    end

    // Compare process: every output on every cycle once reset has been seen.
    initial begin
        forever begin
            @(negedge clk);
            if (m_on) begin
                chk("vin", 32'(vin), 32'(exp_vin));
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("tof_valid", 32'(tof_valid), 32'(exp_valid));
                chk("tof", 32'(tof), 32'(exp_tof));
                chk("tof_chan", 32'(tof_chan), 32'(exp_chan));
                chk("timeout", 32'(timeout), 32'(exp_to));
            end
        end
    end

    task automatic wait_k(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (!(!m_idle && m_k == k) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("wait_k_bound", 32'(n), 32'd0);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (tof_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("wait_valid_bound", 32'(n), 32'd0);
    endtask

    initial begin
        logic [12:0] burst_seen;
        logic [12:0] burst_req;
        time         ts [4];
        int          chs [4];
        int          rr_req [4];
        burst_req = 13'h01C7;
        rr_req = '{0, 2, 0, 2};
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vin", 32'(vin), 32'd0);
        chk("rst_valid", 32'(tof_valid), 32'd0);
        chk("rst_tof", 32'(tof), 32'd0);
        rst = 1'b0;

        // Burst shape and echo capture on channel 0.
        chan_mask = 4'b0001; enable = 1'b1;
        wait_k(1);
        burst_seen[0] = vin[0];
        for (int i = 1; i < 13; i++) begin @(negedge clk); burst_seen[i] = vin[0]; end
        chk("burst_shape", 32'(burst_seen), 32'(burst_req));
        wait_k(24);
        echo = 4'b0001;
        wait_valid();
        chk("echo_tof", 32'(tof), 32'd25);
        chk("echo_timeout", 32'(timeout), 32'd0);
        chk("echo_chan", 32'(tof_chan), 32'd0);
        echo = 4'b0000;

        // Echo only during ringdown blanking gives a timeout.
        wait_k(13);
        echo = 4'b0001;
        wait_k(16);
        echo = 4'b0000;
        wait_valid();
        chk("blank_tof", 32'(tof), 32'd40);
        chk("blank_timeout", 32'(timeout), 32'd1);
        chan_mask = 4'b0101;

        // Reset in the middle of a burst, then round-robin from channel 0.
        wait_k(4);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_vin", 32'(vin), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_valid();
            ts[i] = $time; chs[i] = int'(tof_chan);
        end
        for (int i = 0; i < 4; i++) chk("rr_chan", 32'(chs[i]), 32'(rr_req[i]));
        for (int i = 1; i < 4; i++) chk("rr_period", 32'((ts[i] - ts[i-1]) / 10), 32'd43);

        // Dropping enable mid-slot still completes the slot.
        wait_k(6);
        enable = 1'b0;
        wait_valid();
        chk("drop_chan", 32'(tof_chan), 32'd0);
        @(negedge clk);
        chk("drop_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("drop_vin", 32'(vin), 32'd0);

        // Randomized traffic checked by the model.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic [3:0] flip;
            for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 11) == 0);
            echo = echo ^ flip;
            if ($urandom_range(0, 149) == 0) chan_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) enable = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
